// File: rtl/seq_det_pkg.sv
// Shared definitions for the programmable serial sequence detector:
// FSM state encodings and the default pattern loaded at reset.
package seq_det_pkg;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_HUNT  = 2'd1,
    S_MATCH = 2'd2,
    S_ILL   = 2'd3
  } state_e;

  localparam logic [31:0] PAT_RST_DEF = 32'b11011;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Registered output, one-cycle update latency, no wrap at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/seq_detector_prog.sv
// Programmable serial pattern detector: Moore flag one cycle after the completing
// bit, selectable overlapping/non-overlapping matching, saturating match counter.
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 5,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_RST_DEF[PAT_W-1:0]
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap_en,
  input  logic             cnt_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic [1:0]       state_o
);

  localparam int              FILL_W   = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

  state_e            state_q, state_d;
  logic [FILL_W-1:0] fill_q, fill_d, fill_inc;
  logic [PAT_W-1:0]  hist_q, hist_d, hist_shift;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic              accept;
  logic              hit;

  always_comb begin
    // a pattern load swallows any bit presented in the same cycle
    accept     = in_valid && !pat_load;
    hist_shift = {hist_q[PAT_W-2:0], in_bit};
    fill_inc   = (fill_q >= FILL_MAX) ? FILL_MAX : fill_q + 1'b1;
    hit        = accept && (state_q != S_ILL) &&
                 (hist_shift == pat_q) && (fill_inc == FILL_MAX);

    state_d = state_q;
    fill_d  = fill_q;
    hist_d  = hist_q;
    pat_d   = pat_q;

    if (pat_load) begin
      pat_d   = pat_in;
      fill_d  = '0;
      hist_d  = '0;
      state_d = S_FILL;
    end else if (state_q == S_ILL) begin
      state_d = S_FILL;
      fill_d  = '0;
    end else if (accept) begin
      hist_d = hist_shift;
      if (hit) begin
        state_d = S_MATCH;
        // non-overlapping mode forces a fresh PAT_W bits before the next hit
        fill_d  = overlap_en ? fill_inc : '0;
      end else begin
        fill_d  = fill_inc;
        state_d = (fill_inc < FILL_MAX) ? S_FILL : S_HUNT;
      end
    end else if (state_q == S_MATCH) begin
      state_d = overlap_en ? S_HUNT : S_FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FILL;
      fill_q  <= '0;
      hist_q  <= '0;
      pat_q   <= PAT_RST;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      hist_q  <= hist_d;
      pat_q   <= pat_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hit),
    .clr (cnt_clr),
    .q   (match_cnt)
  );

  assign out     = (state_q == S_MATCH);
  assign state_o = state_q;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed bench for seq_detector_prog: a default-width instance plus a CNT_W=2
// instance sharing the same stimulus for the saturation scenario.
module tb_seq_detector_prog;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       pat_load = 1'b0;
  logic [4:0] pat_in = 5'b0;
  logic       overlap_en = 1'b1;
  logic       cnt_clr = 1'b0;

  logic       out, out_s;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt_s;
  logic [1:0] state_o, state_o_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_detector_prog dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .pat_load   (pat_load),
    .pat_in     (pat_in),
    .overlap_en (overlap_en),
    .cnt_clr    (cnt_clr),
    .out        (out),
    .match_cnt  (match_cnt),
    .state_o    (state_o)
  );

  seq_detector_prog #(.CNT_W(2)) dut_sat (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .pat_load   (pat_load),
    .pat_in     (pat_in),
    .overlap_en (overlap_en),
    .cnt_clr    (cnt_clr),
    .out        (out_s),
    .match_cnt  (match_cnt_s),
    .state_o    (state_o_s)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic send(input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    cyc();
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic load(input logic [4:0] p);
    pat_load = 1'b1;
    pat_in   = p;
    cyc();
    pat_load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_bit = 1'b1; pat_load = 1'b1; pat_in = 5'b11111;
    cyc();
    rst = 1'b0; in_valid = 1'b0; in_bit = 1'b0; pat_load = 1'b0;
    total++; if (out !== 1'b0) begin bad++; $display("FAIL reset_out got=%b exp=0", out); end
    total++; if (match_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", match_cnt); end
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    total++; if (match_cnt_s !== 2'd0) begin bad++; $display("FAIL reset_cnt_sat got=%0d exp=0", match_cnt_s); end
  endtask

  task automatic test_default();
    logic [4:0] s = 5'b11011;
    do_reset(); overlap_en = 1'b1;
    for (int i = 4; i >= 0; i--) begin
      send(s[i]);
      total++; if (out !== 1'(i == 0)) begin bad++; $display("FAIL default_out bit=%0d got=%b exp=%b", 5-i, out, (i == 0)); end
    end
    total++; if (match_cnt !== 8'd1) begin bad++; $display("FAIL default_cnt got=%0d exp=1", match_cnt); end
    total++; if (state_o !== 2'd2) begin bad++; $display("FAIL default_state got=%0d exp=2", state_o); end
    cyc();
    total++; if (out !== 1'b0) begin bad++; $display("FAIL default_pulse got=%b exp=0", out); end
    total++; if (state_o !== 2'd1) begin bad++; $display("FAIL default_exit got=%0d exp=1", state_o); end
  endtask

  task automatic test_overlap();
    logic [7:0] s  = 8'b11011011;
    logic [7:0] em = 8'b00001001;
    do_reset(); overlap_en = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      send(s[i]);
      total++; if (out !== em[i]) begin bad++; $display("FAIL overlap_out bit=%0d got=%b exp=%b", 8-i, out, em[i]); end
    end
    total++; if (match_cnt !== 8'd2) begin bad++; $display("FAIL overlap_cnt got=%0d exp=2", match_cnt); end
  endtask

  task automatic test_non_overlap();
    logic [10:0] s  = 11'b11011011011;
    logic [10:0] em = 11'b00001000001;
    do_reset(); overlap_en = 1'b0;
    for (int i = 10; i >= 0; i--) begin
      send(s[i]);
      total++; if (out !== em[i]) begin bad++; $display("FAIL nonov_out bit=%0d got=%b exp=%b", 11-i, out, em[i]); end
      if (i == 3) begin
        total++; if (match_cnt !== 8'd1) begin bad++; $display("FAIL nonov_cnt8 got=%0d exp=1", match_cnt); end
      end
    end
    total++; if (match_cnt !== 8'd2) begin bad++; $display("FAIL nonov_cnt11 got=%0d exp=2", match_cnt); end
    cyc();
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL nonov_exit got=%0d exp=0", state_o); end
    overlap_en = 1'b1;
  endtask

  task automatic test_pat_load();
    logic [3:0] s1 = 4'b0101;
    logic [4:0] s2 = 5'b10101;
    logic [4:0] s3 = 5'b11011;
    do_reset(); overlap_en = 1'b1;
    pat_load = 1'b1; pat_in = 5'b10101; in_valid = 1'b1; in_bit = 1'b1;
    cyc();
    pat_load = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL load_state got=%0d exp=0", state_o); end
    for (int i = 3; i >= 0; i--) begin
      send(s1[i]);
      total++; if (out !== 1'b0) begin bad++; $display("FAIL load_discard bit=%0d got=%b exp=0", 4-i, out); end
    end
    load(5'b10101);
    for (int i = 4; i >= 0; i--) begin
      send(s2[i]);
      total++; if (out !== 1'(i == 0)) begin bad++; $display("FAIL load_hit bit=%0d got=%b exp=%b", 5-i, out, (i == 0)); end
    end
    load(5'b10101);
    for (int i = 4; i >= 0; i--) begin
      send(s3[i]);
      total++; if (out !== 1'b0) begin bad++; $display("FAIL load_old bit=%0d got=%b exp=0", 5-i, out); end
    end
    total++; if (match_cnt !== 8'd1) begin bad++; $display("FAIL load_cnt got=%0d exp=1", match_cnt); end
  endtask

  task automatic test_saturation();
    logic [16:0] s  = 17'b11011011011011011;
    logic [16:0] em = 17'b00001001001001001;
    do_reset(); overlap_en = 1'b1;
    for (int i = 16; i >= 0; i--) begin
      send(s[i]);
      total++; if (out_s !== em[i]) begin bad++; $display("FAIL sat_out bit=%0d got=%b exp=%b", 17-i, out_s, em[i]); end
    end
    total++; if (match_cnt_s !== 2'd3) begin bad++; $display("FAIL sat_cnt got=%0d exp=3", match_cnt_s); end
    total++; if (match_cnt !== 8'd5) begin bad++; $display("FAIL sat_wide_cnt got=%0d exp=5", match_cnt); end
    send(1'b0);
    send(1'b1);
    cnt_clr = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    cyc();
    cnt_clr = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    total++; if (out_s !== 1'b1) begin bad++; $display("FAIL clr_hit_out got=%b exp=1", out_s); end
    total++; if (match_cnt_s !== 2'd0) begin bad++; $display("FAIL clr_hit_cnt got=%0d exp=0", match_cnt_s); end
    total++; if (match_cnt !== 8'd0) begin bad++; $display("FAIL clr_hit_wide got=%0d exp=0", match_cnt); end
    cyc();
    total++; if (match_cnt_s !== 2'd0) begin bad++; $display("FAIL clr_hold got=%0d exp=0", match_cnt_s); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] s1 = 4'b1101;
    logic [3:0] s2 = 4'b1011;
    do_reset(); overlap_en = 1'b1;
    for (int i = 3; i >= 0; i--) send(s1[i]);
    do_reset();
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL rmid_state got=%0d exp=0", state_o); end
    send(1'b1);
    total++; if (out !== 1'b0) begin bad++; $display("FAIL rmid_first got=%b exp=0", out); end
    for (int i = 3; i >= 0; i--) begin
      send(s2[i]);
      total++; if (out !== 1'(i == 0)) begin bad++; $display("FAIL rmid_full bit=%0d got=%b exp=%b", 5-i, out, (i == 0)); end
    end
    total++; if (match_cnt !== 8'd1) begin bad++; $display("FAIL rmid_cnt got=%0d exp=1", match_cnt); end
  endtask

  task automatic test_idle_hold();
    do_reset(); overlap_en = 1'b1;
    send(1'b1); send(1'b1);
    repeat (3) cyc();
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL idle_state got=%0d exp=0", state_o); end
    send(1'b0); send(1'b1);
    total++; if (out !== 1'b0) begin bad++; $display("FAIL idle_early got=%b exp=0", out); end
    send(1'b1);
    total++; if (out !== 1'b1) begin bad++; $display("FAIL idle_hit got=%b exp=1", out); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] em = 6'b000011;
    do_reset(); overlap_en = 1'b1;
    load(5'b11111);
    for (int i = 5; i >= 0; i--) begin
      send(1'b1);
      total++; if (out !== em[i]) begin bad++; $display("FAIL b2b_out bit=%0d got=%b exp=%b", 6-i, out, em[i]); end
    end
    total++; if (match_cnt !== 8'd2) begin bad++; $display("FAIL b2b_cnt got=%0d exp=2", match_cnt); end
    total++; if (state_o !== 2'd2) begin bad++; $display("FAIL b2b_state got=%0d exp=2", state_o); end
  endtask

  initial begin
    cyc();
    test_reset();
    test_default();
    test_overlap();
    test_non_overlap();
    test_pat_load();
    test_saturation();
    test_reset_mid();
    test_idle_hold();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
